// File: rtl/ptmch_pkg.sv
// Shared types and default sizing for the pattern-match SPI front end.
`timescale 1ns/1ps
package ptmch_pkg;

   localparam int unsigned PTMCH_DATA_W      = 8;
   localparam int unsigned PTMCH_CNT_W       = 8;
   localparam int unsigned PTMCH_TIMEOUT_CYC = 4096;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ABORT = 2'd2
   } spi_rx_st_t;

endpackage

// File: rtl/ptmch_sync2.sv
// Two-flop synchronizer with a selectable reset value.
`timescale 1ns/1ps
module ptmch_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ptmch_spi_rx.sv
// SPI mode-0 slave receiver, oversampled in the CLK200M domain, with valid/ready output.
// Optional mid-word SCLK stall abort is enabled by defining PTMCH_SPI_TIMEOUT_EN.
`timescale 1ns/1ps
module ptmch_spi_rx
   import ptmch_pkg::*;
#(
   parameter int unsigned DATA_W      = PTMCH_DATA_W,
   parameter int unsigned CNT_W       = PTMCH_CNT_W
`ifdef PTMCH_SPI_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = PTMCH_TIMEOUT_CYC
`endif
) (
   input  logic              CLK200M,
   input  logic              RESET_N,
   input  logic              SPI_CS,
   input  logic              SPI_CLK,
   input  logic              SPI_MOSI,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_act,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              frame_err,
   output logic              overrun
);

   localparam int unsigned BIT_W = $clog2(DATA_W + 1);

   logic cs_s, sclk_s, mosi_s;
   logic cs_d, sclk_d;
   logic cs_fall_c, cs_rise_c, sclk_rise_c;

   spi_rx_st_t        state_q, state_nxt;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_nxt;
   logic [DATA_W-2:0] shift_q, shift_nxt;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_nxt;
   logic [DATA_W-1:0] rx_data_q, rx_data_nxt;
   logic              rx_valid_q, rx_valid_nxt;
   logic              frame_act_q, frame_act_nxt;
   logic              frame_err_q, frame_err_nxt;
   logic              overrun_q, overrun_nxt;
   logic [1:0]        warm_q, warm_nxt;
   logic              armed_q, armed_nxt;
   logic              complete_c;
   logic [DATA_W-1:0] word_c;
`ifdef PTMCH_SPI_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0]  tmo_q, tmo_nxt;
`endif

   ptmch_sync2 #(.RST_VAL(1'b1)) u_sync_cs (
      .clk(CLK200M), .rst_n(RESET_N), .d(SPI_CS), .q(cs_s));
   ptmch_sync2 #(.RST_VAL(1'b0)) u_sync_clk (
      .clk(CLK200M), .rst_n(RESET_N), .d(SPI_CLK), .q(sclk_s));
   ptmch_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk(CLK200M), .rst_n(RESET_N), .d(SPI_MOSI), .q(mosi_s));

   assign cs_fall_c   = cs_d & ~cs_s;
   assign cs_rise_c   = ~cs_d & cs_s;
   assign sclk_rise_c = ~sclk_d & sclk_s;

   // A frame may only start after CS has been seen high once the synchronizers
   // have flushed, so a reset released mid-frame waits for the next CS fall.
   always_comb begin
      state_nxt     = state_q;
      bit_cnt_nxt   = bit_cnt_q;
      shift_nxt     = shift_q;
      word_cnt_nxt  = word_cnt_q;
      rx_data_nxt   = rx_data_q;
      rx_valid_nxt  = rx_valid_q;
      frame_act_nxt = frame_act_q;
      frame_err_nxt = 1'b0;
      overrun_nxt   = 1'b0;
      warm_nxt      = {warm_q[0], 1'b1};
      armed_nxt     = armed_q | (warm_q[1] & cs_s);
      complete_c    = 1'b0;
      word_c        = {shift_q, mosi_s};
`ifdef PTMCH_SPI_TIMEOUT_EN
      tmo_nxt       = '0;
`endif

      case (state_q)
         IDLE: begin
            if (armed_q && cs_fall_c) begin
               state_nxt     = SHIFT;
               bit_cnt_nxt   = '0;
               shift_nxt     = '0;
               word_cnt_nxt  = '0;
               frame_act_nxt = 1'b1;
            end
         end
         SHIFT: begin
            if (cs_rise_c) begin
               state_nxt     = IDLE;
               frame_act_nxt = 1'b0;
               bit_cnt_nxt   = '0;
               frame_err_nxt = (bit_cnt_q != '0);
            end else if (sclk_rise_c) begin
               shift_nxt = word_c[DATA_W-2:0];
               if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                  complete_c  = 1'b1;
                  bit_cnt_nxt = '0;
                  if (word_cnt_q != '1) word_cnt_nxt = word_cnt_q + CNT_W'(1);
               end else begin
                  bit_cnt_nxt = bit_cnt_q + BIT_W'(1);
               end
            end
`ifdef PTMCH_SPI_TIMEOUT_EN
            else if (bit_cnt_q != '0) begin
               if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                  state_nxt     = ABORT;
                  frame_err_nxt = 1'b1;
                  bit_cnt_nxt   = '0;
               end else begin
                  tmo_nxt = tmo_q + TMO_W'(1);
               end
            end
`endif
         end
`ifdef PTMCH_SPI_TIMEOUT_EN
         ABORT: begin
            if (cs_rise_c) begin
               state_nxt     = IDLE;
               frame_act_nxt = 1'b0;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase

      // Output holding register: a held, unaccepted word wins over a new one.
      if (complete_c) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_nxt  = word_c;
            rx_valid_nxt = 1'b1;
         end else begin
            overrun_nxt = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge CLK200M or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         word_cnt_q  <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_act_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         warm_q      <= '0;
         armed_q     <= 1'b0;
         cs_d        <= 1'b1;
         sclk_d      <= 1'b0;
`ifdef PTMCH_SPI_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_nxt;
         bit_cnt_q   <= bit_cnt_nxt;
         shift_q     <= shift_nxt;
         word_cnt_q  <= word_cnt_nxt;
         rx_data_q   <= rx_data_nxt;
         rx_valid_q  <= rx_valid_nxt;
         frame_act_q <= frame_act_nxt;
         frame_err_q <= frame_err_nxt;
         overrun_q   <= overrun_nxt;
         warm_q      <= warm_nxt;
         armed_q     <= armed_nxt;
         cs_d        <= cs_s;
         sclk_d      <= sclk_s;
`ifdef PTMCH_SPI_TIMEOUT_EN
         tmo_q       <= tmo_nxt;
`endif
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_act = frame_act_q;
   assign word_cnt  = word_cnt_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_ptmch_spi_rx.sv
// Directed self-checking bench for ptmch_spi_rx (timeout case needs PTMCH_SPI_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_ptmch_spi_rx;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       cs       = 1'b1;
   logic       sclk     = 1'b0;
   logic       mosi     = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_act;
   logic [7:0] word_cnt;
   logic       frame_err;
   logic       overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int ovr_cnt = 0;
   int ferr_cnt = 0;
   int vhi_cnt = 0;
   int vlo_cnt = 0;
   logic [7:0] got_q[$];

   ptmch_spi_rx dut (
      .CLK200M  (clk),
      .RESET_N  (rst_n),
      .SPI_CS   (cs),
      .SPI_CLK  (sclk),
      .SPI_MOSI (mosi),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_act(frame_act),
      .word_cnt (word_cnt),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #2.5 clk = ~clk;

   // Pulse counters and accepted-word log, sampled mid-cycle
   always @(negedge clk) begin
      if (overrun)   ovr_cnt++;
      if (frame_err) ferr_cnt++;
      if (rx_valid) vhi_cnt++; else vlo_cnt++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // 10 MHz SCLK: 10 system cycles low, 10 high
   task automatic spi_bit(input logic b);
      @(negedge clk) mosi = b;
      wait_clks(10);
      sclk = 1'b1;
      wait_clks(10);
      sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] v, input int nbits);
      for (int i = 0; i < nbits; i++) spi_bit(v[7-i]);
   endtask

   task automatic cs_low();
      @(negedge clk) cs = 1'b0;
      wait_clks(10);
   endtask

   task automatic cs_high();
      wait_clks(10);
      cs = 1'b1;
      wait_clks(10);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_clks(4);
      n_tests++;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      n_tests++;
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      n_tests++;
      if (word_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_wcnt: got %h expected 00", word_cnt); end
      n_tests++;
      if ({frame_act, frame_err, overrun} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 000", {frame_act, frame_err, overrun});
      end
      @(negedge clk) rst_n = 1'b1;
      wait_clks(8);
   endtask

   task automatic test_basic();
      int ovr0, ferr0;
      ovr0 = ovr_cnt; ferr0 = ferr_cnt;
      got_q.delete();
      rx_ready = 1'b1;
      cs_low();
      n_tests++;
      if (frame_act !== 1'b1) begin n_fail++; $display("FAIL basic_act: got %b expected 1", frame_act); end
      spi_byte(8'hA5, 8);
      spi_byte(8'h3C, 8);
      wait_clks(5);
      n_tests++;
      if (word_cnt !== 8'd2) begin n_fail++; $display("FAIL basic_wcnt: got %0d expected 2", word_cnt); end
      cs_high();
      n_tests++;
      if (got_q.size() != 2) begin n_fail++; $display("FAIL basic_count: got %0d words expected 2", got_q.size()); end
      else begin
         n_tests++;
         if (got_q[0] !== 8'hA5) begin n_fail++; $display("FAIL basic_w0: got %h expected a5", got_q[0]); end
         n_tests++;
         if (got_q[1] !== 8'h3C) begin n_fail++; $display("FAIL basic_w1: got %h expected 3c", got_q[1]); end
      end
      n_tests++;
      if ((ovr_cnt - ovr0) != 0 || (ferr_cnt - ferr0) != 0) begin
         n_fail++; $display("FAIL basic_errs: got ovr %0d ferr %0d expected 0 0", ovr_cnt - ovr0, ferr_cnt - ferr0);
      end
      n_tests++;
      if (frame_act !== 1'b0) begin n_fail++; $display("FAIL basic_act_end: got %b expected 0", frame_act); end
   endtask

   task automatic test_overrun();
      int ovr0;
      ovr0 = ovr_cnt;
      got_q.delete();
      rx_ready = 1'b0;
      cs_low();
      spi_byte(8'h11, 8);
      wait_clks(5);
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
         n_fail++; $display("FAIL ovr_first: got v=%b d=%h expected v=1 d=11", rx_valid, rx_data);
      end
      spi_byte(8'h22, 8);
      wait_clks(5);
      n_tests++;
      if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_hold: got %h expected 11", rx_data); end
      n_tests++;
      if ((ovr_cnt - ovr0) != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt - ovr0); end
      cs_high();
      n_tests++;
      if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_survive_cs: got %b expected 1", rx_valid); end
      @(posedge clk) #1 rx_ready = 1'b1;
      @(posedge clk) #1 rx_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b expected 0", rx_valid); end
      n_tests++;
      if (got_q.size() != 1 || got_q[0] !== 8'h11) begin
         n_fail++; $display("FAIL ovr_accept: got %0d words first %h expected 1 word 11",
                            got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
      end
   endtask

   task automatic test_frame_err();
      int ferr0, vhi0;
      ferr0 = ferr_cnt; vhi0 = vhi_cnt;
      got_q.delete();
      rx_ready = 1'b1;
      cs_low();
      spi_byte(8'hFF, 5);
      cs_high();
      n_tests++;
      if ((ferr_cnt - ferr0) != 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - ferr0); end
      n_tests++;
      if (vhi_cnt != vhi0) begin n_fail++; $display("FAIL ferr_novalid: got %0d valid cycles expected 0", vhi_cnt - vhi0); end
      cs_low();
      spi_byte(8'h5A, 8);
      wait_clks(5);
      n_tests++;
      if (word_cnt !== 8'd1) begin n_fail++; $display("FAIL ferr_wcnt: got %0d expected 1", word_cnt); end
      cs_high();
      n_tests++;
      if (got_q.size() != 1 || got_q[0] !== 8'h5A || (ferr_cnt - ferr0) != 1) begin
         n_fail++; $display("FAIL ferr_next: got %0d words first %h ferr %0d expected 1 word 5a ferr 1",
                            got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, ferr_cnt - ferr0);
      end
   endtask

   task automatic test_same_cycle();
      int ovr0, vlo0;
      ovr0 = ovr_cnt;
      got_q.delete();
      rx_ready = 1'b0;
      cs_low();
      spi_byte(8'h77, 8);
      wait_clks(5);
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin
         n_fail++; $display("FAIL same_hold: got v=%b d=%h expected v=1 d=77", rx_valid, rx_data);
      end
      spi_byte(8'h99, 7);
      @(negedge clk) mosi = 1'b1;
      wait_clks(10);
      vlo0 = vlo_cnt;
      sclk = 1'b1;
      // Sync delay puts completion in the cycle ending at the third posedge
      @(posedge clk); @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      wait_clks(8);
      sclk = 1'b0;
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h99) begin
         n_fail++; $display("FAIL same_new: got v=%b d=%h expected v=1 d=99", rx_valid, rx_data);
      end
      n_tests++;
      if (vlo_cnt != vlo0) begin n_fail++; $display("FAIL same_gap: got %0d low cycles expected 0", vlo_cnt - vlo0); end
      n_tests++;
      if ((ovr_cnt - ovr0) != 0) begin n_fail++; $display("FAIL same_ovr: got %0d expected 0", ovr_cnt - ovr0); end
      n_tests++;
      if (got_q.size() != 1 || got_q[0] !== 8'h77) begin
         n_fail++; $display("FAIL same_accept: got %0d words first %h expected 1 word 77",
                            got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
      end
      cs_high();
      rx_ready = 1'b1;
      wait_clks(4);
   endtask

   task automatic test_reset_mid();
      int vhi0;
      rx_ready = 1'b1;
      cs_low();
      spi_byte(8'hC3, 4);
      @(negedge clk) rst_n = 1'b0;
      #1;
      n_tests++;
      if ({frame_act, rx_valid, word_cnt} !== 10'd0) begin
         n_fail++; $display("FAIL rmid_clear: got act=%b v=%b cnt=%h expected 0 0 00", frame_act, rx_valid, word_cnt);
      end
      wait_clks(5);
      rst_n = 1'b1;
      wait_clks(5);
      vhi0 = vhi_cnt;
      got_q.delete();
      spi_byte(8'hE7, 8);
      wait_clks(5);
      n_tests++;
      if (vhi_cnt != vhi0) begin n_fail++; $display("FAIL rmid_noword: got %0d valid cycles expected 0", vhi_cnt - vhi0); end
      n_tests++;
      if (frame_act !== 1'b0 || word_cnt !== 8'd0) begin
         n_fail++; $display("FAIL rmid_idle: got act=%b cnt=%h expected 0 00", frame_act, word_cnt);
      end
      cs_high();
      cs_low();
      spi_byte(8'h81, 8);
      cs_high();
      n_tests++;
      if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
         n_fail++; $display("FAIL rmid_resume: got %0d words first %h expected 1 word 81",
                            got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
      end
   endtask

`ifdef PTMCH_SPI_TIMEOUT_EN
   task automatic test_timeout();
      int ferr0, vhi0;
      ferr0 = ferr_cnt; vhi0 = vhi_cnt;
      rx_ready = 1'b1;
      cs_low();
      spi_byte(8'hA0, 3);
      wait_clks(4200);
      n_tests++;
      if ((ferr_cnt - ferr0) != 1) begin n_fail++; $display("FAIL tmo_pulse: got %0d expected 1", ferr_cnt - ferr0); end
      spi_byte(8'hFF, 8);
      wait_clks(5);
      n_tests++;
      if (vhi_cnt != vhi0 || frame_act !== 1'b1) begin
         n_fail++; $display("FAIL tmo_ignore: got %0d valid cycles act=%b expected 0 act=1", vhi_cnt - vhi0, frame_act);
      end
      cs_high();
      n_tests++;
      if ((ferr_cnt - ferr0) != 1 || frame_act !== 1'b0) begin
         n_fail++; $display("FAIL tmo_end: got ferr %0d act=%b expected 1 act=0", ferr_cnt - ferr0, frame_act);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_frame_err();
      test_same_cycle();
      test_reset_mid();
`ifdef PTMCH_SPI_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
